// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : store_buffer
// Brief    : FIFO store buffer between the MEM stage and the D-cache/memory,
//            with youngest-store coalescing and byte-wise load forwarding.
// Revision : 1.0 - initial release
// ============================================================================
module store_buffer #(
    parameter int DEPTH    = 4,
    parameter int PTR_BITS = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enq_valid,
    input  logic [31:0]         enq_addr,
    input  logic [31:0]         enq_data,
    input  logic [3:0]          enq_byte_en,
    output logic                enq_ready,
    input  logic                drain_ready,
    output logic                drain_valid,
    output logic [31:0]         drain_addr,
    output logic [31:0]         drain_data,
    output logic [3:0]          drain_byte_en,
    input  logic [31:0]         ld_addr,
    output logic [3:0]          fwd_byte_en,
    output logic [31:0]         fwd_data,
    output logic                fwd_full,
    output logic [PTR_BITS:0]   count,
    output logic                full,
    output logic                empty,
    output logic                overflow
);

    localparam logic [PTR_BITS:0]   c_depth = (PTR_BITS+1)'(DEPTH);
    localparam logic [PTR_BITS-1:0] c_one   = PTR_BITS'(1);

    logic [29:0]         r_addr  [DEPTH];
    logic [31:0]         r_data  [DEPTH];
    logic [3:0]          r_be    [DEPTH];
    logic [DEPTH-1:0]    r_valid;
    logic [PTR_BITS-1:0] r_head;
    logic [PTR_BITS-1:0] r_tail;
    logic [PTR_BITS:0]   r_count;
    logic                r_overflow;

    logic                w_empty;
    logic                w_full;
    logic                w_drain_fire;
    logic                w_enq_fire;
    logic                w_coalesce;
    logic                w_alloc;
    logic [PTR_BITS-1:0] w_young;
    logic [PTR_BITS-1:0] w_idx;
    logic [PTR_BITS:0]   w_count_next;
    logic [3:0]          w_fwd_be;
    logic [31:0]         w_fwd_data;
    logic                w_unused;

    assign w_unused     = &{1'b0, enq_addr[1:0], ld_addr[1:0]};

    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == c_depth);
    assign w_drain_fire = !w_empty && drain_ready;
    assign enq_ready    = !w_full || w_drain_fire;
    assign w_enq_fire   = enq_valid && enq_ready;
    assign w_young      = r_tail - c_one;

    // A lone entry leaving this cycle cannot absorb the new store.
    assign w_coalesce   = w_enq_fire && !w_empty &&
                          (r_addr[w_young] == enq_addr[31:2]) &&
                          !((r_count == (PTR_BITS+1)'(1)) && w_drain_fire);
    assign w_alloc      = w_enq_fire && !w_coalesce;

    always_comb begin
        w_count_next = r_count;
        if (w_alloc && !w_drain_fire)
            w_count_next = r_count + (PTR_BITS+1)'(1);
        else if (!w_alloc && w_drain_fire)
            w_count_next = r_count - (PTR_BITS+1)'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
                r_be[i]   <= '0;
            end
            r_valid    <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_drain_fire) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + c_one;
            end
            // When full, tail==head: the set below overrides the clear above.
            if (w_coalesce) begin
                for (int b = 0; b < 4; b++)
                    if (enq_byte_en[b])
                        r_data[w_young][8*b +: 8] <= enq_data[8*b +: 8];
                r_be[w_young] <= r_be[w_young] | enq_byte_en;
            end else if (w_alloc) begin
                r_addr[r_tail]  <= enq_addr[31:2];
                r_data[r_tail]  <= enq_data;
                r_be[r_tail]    <= enq_byte_en;
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + c_one;
            end
            r_count <= w_count_next;
            if (enq_valid && !enq_ready)
                r_overflow <= 1'b1;
        end
    end

    // Oldest to youngest so the youngest matching store wins each byte.
    always_comb begin
        w_fwd_be   = '0;
        w_fwd_data = '0;
        w_idx      = r_head;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_head + PTR_BITS'(i);
            if (r_valid[w_idx] && (r_addr[w_idx] == ld_addr[31:2])) begin
                for (int b = 0; b < 4; b++) begin
                    if (r_be[w_idx][b]) begin
                        w_fwd_be[b]           = 1'b1;
                        w_fwd_data[8*b +: 8] = r_data[w_idx][8*b +: 8];
                    end
                end
            end
        end
    end

    assign drain_valid   = !w_empty;
    assign drain_addr    = w_empty ? '0 : {r_addr[r_head], 2'b00};
    assign drain_data    = w_empty ? '0 : r_data[r_head];
    assign drain_byte_en = w_empty ? '0 : r_be[r_head];
    assign fwd_byte_en   = w_fwd_be;
    assign fwd_data      = w_fwd_data;
    assign fwd_full      = (w_fwd_be == 4'hF);
    assign count         = r_count;
    assign full          = w_full;
    assign empty         = w_empty;
    assign overflow      = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_buffer
// Brief    : Scoreboard bench for store_buffer; a queue model predicts drain
//            order, coalescing, forwarding and status flags cycle by cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_store_buffer;

    localparam int c_depth = 4;

    logic        clk;
    logic        reset_n;
    logic        enq_valid;
    logic [31:0] enq_addr;
    logic [31:0] enq_data;
    logic [3:0]  enq_byte_en;
    logic        enq_ready;
    logic        drain_ready;
    logic        drain_valid;
    logic [31:0] drain_addr;
    logic [31:0] drain_data;
    logic [3:0]  drain_byte_en;
    logic [31:0] ld_addr;
    logic [3:0]  fwd_byte_en;
    logic [31:0] fwd_data;
    logic        fwd_full;
    logic [2:0]  count;
    logic        full;
    logic        empty;
    logic        overflow;

    store_buffer #(.DEPTH(c_depth), .PTR_BITS(2)) u_dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enq_valid     (enq_valid),
        .enq_addr      (enq_addr),
        .enq_data      (enq_data),
        .enq_byte_en   (enq_byte_en),
        .enq_ready     (enq_ready),
        .drain_ready   (drain_ready),
        .drain_valid   (drain_valid),
        .drain_addr    (drain_addr),
        .drain_data    (drain_data),
        .drain_byte_en (drain_byte_en),
        .ld_addr       (ld_addr),
        .fwd_byte_en   (fwd_byte_en),
        .fwd_data      (fwd_data),
        .fwd_full      (fwd_full),
        .count         (count),
        .full          (full),
        .empty         (empty),
        .overflow      (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } ent_t;

    ent_t q[$];
    logic r_exp_ovf;
    int   n_checks;
    int   n_pass;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    endtask

    // Expected forwarding result from the model queue, oldest first.
    task automatic model_fwd(input logic [31:0] la, output logic [3:0] be, output logic [31:0] d);
        be = '0;
        d  = '0;
        foreach (q[i]) begin
            if (q[i].addr[31:2] == la[31:2]) begin
                for (int b = 0; b < 4; b++) begin
                    if (q[i].be[b]) begin
                        be[b]       = 1'b1;
                        d[8*b +: 8] = q[i].data[8*b +: 8];
                    end
                end
            end
        end
    endtask

    // One clock: drive at negedge, check combinational outputs, update model at posedge.
    task automatic cycle(input logic ev, input logic [31:0] ea, input logic [31:0] ed,
                         input logic [3:0] eb, input logic dr, input logic [31:0] la);
        logic        e_empty, e_full, dfire, e_ready, efire, coal;
        logic [3:0]  f_be;
        logic [31:0] f_d;
        ent_t        t;
        enq_valid   = ev;
        enq_addr    = ea;
        enq_data    = ed;
        enq_byte_en = eb;
        drain_ready = dr;
        ld_addr     = la;
        #1;
        e_empty = (q.size() == 0);
        e_full  = (q.size() == c_depth);
        dfire   = !e_empty && dr;
        e_ready = !e_full || dfire;
        efire   = ev && e_ready;
        coal    = efire && !e_empty && (q[q.size()-1].addr[31:2] == ea[31:2]) &&
                  !((q.size() == 1) && dfire);
        check("count", 32'(count), 32'(q.size()));
        check("empty", 32'(empty), 32'(e_empty));
        check("full", 32'(full), 32'(e_full));
        check("drain_valid", 32'(drain_valid), 32'(!e_empty));
        check("enq_ready", 32'(enq_ready), 32'(e_ready));
        check("overflow", 32'(overflow), 32'(r_exp_ovf));
        if (!e_empty) begin
            check("drain_addr", drain_addr, q[0].addr);
            check("drain_data", drain_data, q[0].data);
            check("drain_be", 32'(drain_byte_en), 32'(q[0].be));
        end else begin
            check("drain_addr_idle", drain_addr, 32'h0);
        end
        model_fwd(la, f_be, f_d);
        check("fwd_be", 32'(fwd_byte_en), 32'(f_be));
        check("fwd_data", fwd_data, f_d);
        check("fwd_full", 32'(fwd_full), 32'(f_be == 4'hF));
        @(posedge clk);
        if (dfire) void'(q.pop_front());
        if (coal) begin
            t = q[q.size()-1];
            for (int b = 0; b < 4; b++)
                if (eb[b]) t.data[8*b +: 8] = ed[8*b +: 8];
            t.be = t.be | eb;
            q[q.size()-1] = t;
        end else if (efire) begin
            t.addr = {ea[31:2], 2'b00};
            t.data = ed;
            t.be   = eb;
            q.push_back(t);
        end
        if (ev && !e_ready) r_exp_ovf = 1'b1;
        @(negedge clk);
    endtask

    task automatic drain_all();
        for (int k = 0; k < 12 && q.size() != 0; k++)
            cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0);
        check("drained_empty", 32'(empty), 32'h1);
    endtask

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        r_exp_ovf   = 1'b0;
        reset_n     = 1'b0;
        enq_valid   = 1'b0;
        enq_addr    = '0;
        enq_data    = '0;
        enq_byte_en = '0;
        drain_ready = 1'b0;
        ld_addr     = '0;
        #1;
        check("rst_empty", 32'(empty), 32'h1);
        check("rst_full", 32'(full), 32'h0);
        check("rst_enq_ready", 32'(enq_ready), 32'h1);
        check("rst_fwd_be", 32'(fwd_byte_en), 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Fill to full with drain stalled, then a dropped fifth store.
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 32'h100 + 32'(4*i), 32'hA000_0000 + 32'(i), 4'hF, 1'b0, 32'h104);
        cycle(1'b1, 32'h110, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h10C);
        check("ovf_sticky", 32'(overflow), 32'h1);
        drain_all();

        // Coalesce two byte writes to one word.
        cycle(1'b1, 32'h200, 32'h0000_00AA, 4'b0001, 1'b0, 32'h200);
        cycle(1'b1, 32'h201, 32'h0000_BB00, 4'b0010, 1'b0, 32'h200);
        check("coal_data", drain_data, 32'h0000_BBAA);
        check("coal_be", 32'(drain_byte_en), 32'h3);
        drain_all();

        // Youngest-wins forwarding across a non-matching entry.
        cycle(1'b1, 32'h300, 32'h1122_3344, 4'hF, 1'b0, 32'h0);
        cycle(1'b1, 32'h304, 32'h0000_0000, 4'hF, 1'b0, 32'h0);
        cycle(1'b1, 32'h300, 32'h0000_0055, 4'b0001, 1'b0, 32'h302);
        cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h302);
        check("fwd_const", fwd_data, 32'h1122_3355);
        cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h308);
        check("fwd_miss", 32'(fwd_byte_en), 32'h0);
        cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h300);
        drain_all();

        // Full with simultaneous drain and enqueue; then count==1 no-coalesce.
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 32'h400 + 32'(4*i), 32'hB000_0000 + 32'(i), 4'hF, 1'b0, 32'h0);
        cycle(1'b1, 32'h500, 32'h5555_5555, 4'hF, 1'b1, 32'h500);
        check("full_swap_count", 32'(count), 32'h4);
        drain_all();
        cycle(1'b1, 32'h600, 32'h0000_0011, 4'b0001, 1'b0, 32'h600);
        cycle(1'b1, 32'h600, 32'h0000_2200, 4'b0010, 1'b1, 32'h600);
        check("one_swap_count", 32'(count), 32'h1);
        check("one_swap_be", 32'(drain_byte_en), 32'h2);
        drain_all();

        // Mixed random traffic over a few words.
        for (int k = 0; k < 80; k++)
            cycle(1'($urandom_range(0, 1)), 32'h700 + 32'(4*$urandom_range(0, 2)),
                  $urandom, 4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)),
                  32'h700 + 32'(4*$urandom_range(0, 2)));

        // Asynchronous reset mid-operation.
        cycle(1'b1, 32'h800, 32'h1, 4'hF, 1'b0, 32'h0);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_empty", 32'(empty), 32'h1);
        check("arst_count", 32'(count), 32'h0);
        check("arst_drain_valid", 32'(drain_valid), 32'h0);
        check("arst_overflow", 32'(overflow), 32'h0);
        q.delete();
        r_exp_ovf = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h800);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
